// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the RV32I datapath control set.
// Define PERF_COUNTERS_EN to build the cycle/instret performance counters.
module multicycle_control_unit #(
   parameter bit RESET_TRAP_CLR = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instruction_code,
   input  logic        N,
   input  logic        Z,
   input  logic        C,
   input  logic        V,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   output logic        imem_req,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic        PCSrc,
   output logic        ALUSrc,
   output logic        MemtoReg,
   output logic        RegWrite,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [2:0]  MemUnit,
   output logic        Branch,
   output logic [4:0]  ALUControl,
   output logic        illegal,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instret_cnt
);

   typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StTrap} state_e;

   state_e     state_q;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_b5;
   logic       is_r, is_i, is_load, is_store, is_branch, is_lui, is_mem;
   logic       mem_f3_bad, br_f3_bad, op_legal, br_taken, trap_entry;
   logic       alu_src_dec;
   logic [4:0] alu_ctl_dec;
   logic       illegal_q;
   logic       unused_instr;

   assign opcode    = instruction_code[6:0];
   assign funct3    = instruction_code[14:12];
   assign funct7_b5 = instruction_code[30];
   assign unused_instr = ^{instruction_code[31], instruction_code[29:15],
                           instruction_code[11:7]};

   assign is_r      = (opcode == 7'b0110011);
   assign is_i      = (opcode == 7'b0010011);
   assign is_load   = (opcode == 7'b0000011);
   assign is_store  = (opcode == 7'b0100011);
   assign is_branch = (opcode == 7'b1100011);
   assign is_lui    = (opcode == 7'b0110111);
   assign is_mem    = is_load | is_store;

   assign mem_f3_bad = (funct3 == 3'd3) || (funct3[2:1] == 2'b11);
   assign br_f3_bad  = (funct3[2:1] == 2'b01);
   assign op_legal   = is_r | is_i | is_branch | is_lui | (is_mem & ~mem_f3_bad);
   assign trap_entry = ((state_q == StDecode) && !op_legal) ||
                       ((state_q == StExec) && is_branch && br_f3_bad);

   // Flags come from the SUB issued in the same EXEC cycle.
   always_comb begin
      br_taken = 1'b0;
      case (funct3)
         3'b000:  br_taken = Z;
         3'b001:  br_taken = ~Z;
         3'b100:  br_taken = N ^ V;
         3'b101:  br_taken = ~(N ^ V);
         3'b110:  br_taken = ~C;
         3'b111:  br_taken = C;
         default: br_taken = 1'b0;
      endcase
   end

   always_comb begin
      alu_src_dec = 1'b1;
      alu_ctl_dec = 5'd0;
      if (is_r) begin
         alu_src_dec = 1'b0;
         alu_ctl_dec = {1'b0, funct7_b5, funct3};
      end else if (is_i) begin
         alu_ctl_dec = {1'b0, funct7_b5 & (funct3 == 3'b101), funct3};
      end else if (is_lui) begin
         alu_ctl_dec = 5'b10000;
      end else if (is_branch) begin
         alu_src_dec = 1'b0;
         alu_ctl_dec = 5'b01000;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StFetch;
      end else begin
         case (state_q)
            StFetch:  if (imem_ready) state_q <= StDecode;
            StDecode: state_q <= op_legal ? StExec : StTrap;
            StExec: begin
               if (is_branch)   state_q <= br_f3_bad ? StTrap : StFetch;
               else if (is_mem) state_q <= StMem;
               else             state_q <= StWb;
            end
            StMem:    if (dmem_ready) state_q <= is_load ? StWb : StFetch;
            StWb:     state_q <= StFetch;
            StTrap:   state_q <= StTrap;
            default:  state_q <= StFetch;
         endcase
      end
   end

   // Debug builds keep the trap flag across reset so the cause can be inspected.
   if (RESET_TRAP_CLR) begin : g_trap_clr
      always_ff @(posedge clk or posedge rst) begin
         if (rst)             illegal_q <= 1'b0;
         else if (trap_entry) illegal_q <= 1'b1;
      end
   end else begin : g_trap_keep
      always_ff @(posedge clk) begin
         if (trap_entry) illegal_q <= 1'b1;
      end
   end

   assign illegal = illegal_q;

   // Outputs follow state directly so ready and flag responses land in the same cycle.
   always_comb begin
      imem_req   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      PCSrc      = 1'b0;
      ALUSrc     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      MemUnit    = 3'd0;
      Branch     = 1'b0;
      ALUControl = 5'd0;
      if (!rst) begin
         case (state_q)
            StFetch: begin
               imem_req = 1'b1;
               IRWrite  = imem_ready;
               PCWrite  = imem_ready;
            end
            StExec: begin
               ALUSrc     = alu_src_dec;
               ALUControl = alu_ctl_dec;
               Branch     = is_branch;
               PCWrite    = is_branch & br_taken;
               PCSrc      = is_branch & br_taken;
            end
            StMem: begin
               ALUSrc     = alu_src_dec;
               ALUControl = alu_ctl_dec;
               MemUnit    = funct3;
               MemRead    = is_load;
               MemWrite   = is_store;
            end
            StWb: begin
               ALUSrc     = alu_src_dec;
               ALUControl = alu_ctl_dec;
               RegWrite   = 1'b1;
               MemtoReg   = is_load;
            end
            default: ;
         endcase
      end
   end

`ifdef PERF_COUNTERS_EN
   logic [31:0] cycle_q, instret_q;
   logic        retire;

   assign retire = (state_q == StWb) ||
                   ((state_q == StMem) && is_store && dmem_ready) ||
                   ((state_q == StExec) && is_branch && !br_f3_bad);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_q   <= 32'd0;
         instret_q <= 32'd0;
      end else if (state_q != StTrap) begin
         cycle_q <= cycle_q + 32'd1;
         if (retire) instret_q <= instret_q + 32'd1;
      end
   end

   assign cycle_cnt   = cycle_q;
   assign instret_cnt = instret_q;
`else
   assign cycle_cnt   = 32'd0;
   assign instret_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed cases plus a random instruction
// stream checked cycle by cycle against an instruction-level expectation model.
module tb_multicycle_control_unit;

   typedef struct packed {
      logic       imem_req;
      logic       IRWrite;
      logic       PCWrite;
      logic       PCSrc;
      logic       ALUSrc;
      logic       MemtoReg;
      logic       RegWrite;
      logic       MemRead;
      logic       MemWrite;
      logic [2:0] MemUnit;
      logic       Branch;
      logic [4:0] ALUControl;
      logic       illegal;
   } ctl_t;

   localparam int ClsBad = -1, ClsR = 0, ClsI = 1, ClsLd = 2, ClsSt = 3, ClsBr = 4, ClsLui = 5;
`ifdef PERF_COUNTERS_EN
   localparam bit Perf = 1'b1;
`else
   localparam bit Perf = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instruction_code;
   logic        N, Z, C, V, imem_ready, dmem_ready;
   logic        imem_req, IRWrite, PCWrite, PCSrc, ALUSrc, MemtoReg, RegWrite;
   logic        MemRead, MemWrite, Branch, illegal;
   logic [2:0]  MemUnit;
   logic [4:0]  ALUControl;
   logic [31:0] cycle_cnt, instret_cnt;
   ctl_t        obs;

   int checks = 0;
   int errors = 0;
   int exp_cycles = 0;
   int exp_instret = 0;

   logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
   logic [2:0] br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

   always #5 clk = ~clk;

   multicycle_control_unit dut (
      .clk              (clk),
      .rst              (rst),
      .instruction_code (instruction_code),
      .N                (N),
      .Z                (Z),
      .C                (C),
      .V                (V),
      .imem_ready       (imem_ready),
      .dmem_ready       (dmem_ready),
      .imem_req         (imem_req),
      .IRWrite          (IRWrite),
      .PCWrite          (PCWrite),
      .PCSrc            (PCSrc),
      .ALUSrc           (ALUSrc),
      .MemtoReg         (MemtoReg),
      .RegWrite         (RegWrite),
      .MemRead          (MemRead),
      .MemWrite         (MemWrite),
      .MemUnit          (MemUnit),
      .Branch           (Branch),
      .ALUControl       (ALUControl),
      .illegal          (illegal),
      .cycle_cnt        (cycle_cnt),
      .instret_cnt      (instret_cnt)
   );

   assign obs = {imem_req, IRWrite, PCWrite, PCSrc, ALUSrc, MemtoReg, RegWrite, MemRead,
                 MemWrite, MemUnit, Branch, ALUControl, illegal};

   function automatic ctl_t mask_all();
      return '1;
   endfunction

   // ALU selects are only defined while the ALU is in use (EXEC/MEM).
   function automatic ctl_t mask_no_alu();
      ctl_t m;
      m            = '1;
      m.ALUSrc     = 1'b0;
      m.ALUControl = 5'd0;
      return m;
   endfunction

   function automatic int op_class(input logic [6:0] op);
      case (op)
         7'b0110011: return ClsR;
         7'b0010011: return ClsI;
         7'b0000011: return ClsLd;
         7'b0100011: return ClsSt;
         7'b1100011: return ClsBr;
         7'b0110111: return ClsLui;
         default:    return ClsBad;
      endcase
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int          k;
      w = $urandom;
      k = $urandom_range(0, 5);
      case (k)
         0: w[6:0] = 7'b0110011;
         1: w[6:0] = 7'b0010011;
         2: begin w[6:0] = 7'b0000011; w[14:12] = ld_f3[$urandom_range(0, 4)]; end
         3: begin w[6:0] = 7'b0100011; w[14:12] = 3'($urandom_range(0, 2)); end
         4: begin w[6:0] = 7'b1100011; w[14:12] = br_f3[$urandom_range(0, 5)]; end
         default: w[6:0] = 7'b0110111;
      endcase
      return w;
   endfunction

   task automatic rand_flags();
      {N, Z, C, V} = 4'($urandom);
   endtask

   task automatic check_ctl(input string tag, input ctl_t want, input ctl_t mask);
      ctl_t got;
      got = obs & mask;
      checks++;
      assert (got === (want & mask)) else begin
         errors++;
         $error("FAIL %s: got %h want %h", tag, got, want & mask);
      end
   endtask

   task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   task automatic check_cnt(input string tag);
      check32({tag, " cycle_cnt"}, cycle_cnt, Perf ? 32'(exp_cycles) : 32'd0);
      check32({tag, " instret_cnt"}, instret_cnt, Perf ? 32'(exp_instret) : 32'd0);
   endtask

   // Called at a falling edge with inputs applied; samples mid-cycle, then steps one clock.
   task automatic tick(input string tag, input ctl_t want, input ctl_t mask, input bit trap);
      #2;
      check_ctl(tag, want, mask);
      if (!trap) exp_cycles++;
      @(negedge clk);
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      instruction_code = $urandom;
      rand_flags();
      #2;
      check_ctl("reset outputs", '0, mask_all());
      check32("reset cycle_cnt", cycle_cnt, 32'd0);
      check32("reset instret_cnt", instret_cnt, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_cycles  = 0;
      exp_instret = 0;
   endtask

   // rel: 0 random operands, 1 force equal, 2 force unequal (branches only)
   task automatic run_instr(input string name, input logic [31:0] ins, input int iw,
                            input int dw, input int rel, input bit abort_mem);
      ctl_t               e;
      logic [2:0]         f3;
      int                 cls;
      bit                 legal, taken;
      logic [31:0]        a, b, diff;
      logic signed [31:0] sa, sb;
      f3  = ins[14:12];
      cls = op_class(ins[6:0]);
      check_cnt(name);
      for (int i = 0; i <= iw; i++) begin
         imem_ready = (i == iw);
         dmem_ready = 1'($urandom);
         instruction_code = $urandom;
         rand_flags();
         e = '0;
         e.imem_req = 1'b1;
         e.IRWrite  = (i == iw);
         e.PCWrite  = (i == iw);
         tick({name, " fetch"}, e, mask_no_alu(), 1'b0);
      end
      instruction_code = ins;
      imem_ready = 1'($urandom);
      dmem_ready = 1'($urandom);
      rand_flags();
      tick({name, " decode"}, '0, mask_no_alu(), 1'b0);

      legal = (cls != ClsBad) &&
              !((cls == ClsLd || cls == ClsSt) && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7));
      if (!legal) begin
         for (int i = 0; i < 3; i++) begin
            imem_ready = 1'b1;
            dmem_ready = 1'b1;
            rand_flags();
            e = '0;
            e.illegal = 1'b1;
            tick({name, " trap"}, e, mask_all(), 1'b1);
         end
         check_cnt({name, " trap"});
         return;
      end

      imem_ready = 1'($urandom);
      dmem_ready = 1'($urandom);
      rand_flags();
      e = '0;
      case (cls)
         ClsR: e.ALUControl = {1'b0, ins[30], f3};
         ClsI: begin
            e.ALUSrc     = 1'b1;
            e.ALUControl = {1'b0, ins[30] & (f3 == 3'd5), f3};
         end
         ClsLd, ClsSt: e.ALUSrc = 1'b1;
         ClsLui: begin
            e.ALUSrc     = 1'b1;
            e.ALUControl = 5'b10000;
         end
         default: begin
            // Flags derived from real operands; expected outcome from direct comparison.
            a = $urandom;
            b = $urandom;
            if (rel == 1 || (rel == 0 && $urandom_range(0, 3) == 0)) b = a;
            if (rel == 2 && b == a) b = a + 32'd1;
            diff = a - b;
            N = diff[31];
            Z = (diff == 32'd0);
            C = (a >= b);
            V = (a[31] != b[31]) && (diff[31] != a[31]);
            sa = a;
            sb = b;
            case (f3)
               3'd0:    taken = (a == b);
               3'd1:    taken = (a != b);
               3'd4:    taken = (sa < sb);
               3'd5:    taken = (sa >= sb);
               3'd6:    taken = (a < b);
               default: taken = (a >= b);
            endcase
            e.Branch     = 1'b1;
            e.ALUControl = 5'b01000;
            e.PCWrite    = taken;
            e.PCSrc      = taken;
         end
      endcase
      tick({name, " exec"}, e, mask_all(), 1'b0);
      if (cls == ClsBr) begin
         exp_instret++;
         return;
      end

      if (cls == ClsLd || cls == ClsSt) begin
         for (int i = 0; i <= dw; i++) begin
            dmem_ready = (i == dw) && !abort_mem;
            imem_ready = 1'($urandom);
            rand_flags();
            e = '0;
            e.ALUSrc   = 1'b1;
            e.MemUnit  = f3;
            e.MemRead  = (cls == ClsLd);
            e.MemWrite = (cls == ClsSt);
            if (abort_mem) begin
               #2 check_ctl({name, " mem before rst"}, e, mask_all());
               #1 rst = 1'b1;
               #1 check_ctl({name, " mem async rst"}, '0, mask_all());
               @(negedge clk);
               rst = 1'b0;
               exp_cycles  = 0;
               exp_instret = 0;
               return;
            end
            tick({name, " mem"}, e, mask_all(), 1'b0);
         end
         if (cls == ClsSt) begin
            exp_instret++;
            return;
         end
      end

      imem_ready = 1'($urandom);
      dmem_ready = 1'($urandom);
      rand_flags();
      e = '0;
      e.RegWrite = 1'b1;
      e.MemtoReg = (cls == ClsLd);
      tick({name, " wb"}, e, mask_no_alu(), 1'b0);
      exp_instret++;
   endtask

   initial begin
      rst = 1'b1;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      instruction_code = 32'd0;
      {N, Z, C, V} = 4'd0;
      repeat (2) @(negedge clk);
      reset_dut();

      run_instr("add x3,x1,x2", 32'h002081B3, 0, 0, 0, 1'b0);
      run_instr("lw x5,4(x1)", 32'h0040A283, 0, 3, 0, 1'b0);
      run_instr("beq taken", 32'h00208463, 0, 0, 1, 1'b0);
      run_instr("beq not taken", 32'h00208463, 0, 0, 2, 1'b0);
      run_instr("add fetch wait", 32'h002081B3, 2, 0, 0, 1'b0);
      run_instr("srai", 32'h4030D093, 0, 0, 0, 1'b0);
      run_instr("lui", 32'h123450B7, 1, 0, 0, 1'b0);
      run_instr("sw", 32'h0020A423, 0, 1, 0, 1'b0);

      run_instr("opcode 7f", 32'h0000007F, 0, 0, 0, 1'b0);
      reset_dut();
      run_instr("add after trap", 32'h002081B3, 0, 0, 0, 1'b0);

      run_instr("sw rst in mem", 32'h0020A423, 0, 2, 0, 1'b1);
      run_instr("add after rst", 32'h002081B3, 1, 0, 0, 1'b0);

      run_instr("load f3 3", 32'h00003003, 0, 0, 0, 1'b0);
      reset_dut();

      for (int i = 0; i < 10; i++) run_instr("addi", 32'h00108093, 0, 0, 0, 1'b0);
      check32("10 addi cycle_cnt", cycle_cnt, Perf ? 32'd40 : 32'd0);
      check32("10 addi instret_cnt", instret_cnt, Perf ? 32'd10 : 32'd0);

      for (int i = 0; i < 80; i++) begin
         run_instr("random", rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3), 0, 1'b0);
      end
      check_cnt("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
